wb_core_bridge: RTL and testbench
=================================

# wb_core_bridge

Parametrised, buffered successor to the single-shot core-to-Wishbone adapter. It sits between an RV32I core's load/store port and the Wishbone side of the NI. Core requests are queued in a request FIFO so the core can post requests back-to-back. The block drives Wishbone classic single transfers in order and returns one response per request, carrying read data and an error flag (slave `wb_err_i` or bus timeout).

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width; multiple of 8; `SW = DW/8`.
- `REQ_DEPTH`, 4, request FIFO depth; power of two, ≥2.
- `TIMEOUT`, 255, max cycles in BUS without ack/err before abort; 0 disables the timeout.

Ports:
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `core_req_i`  in  1  request valid.
- `core_we_i`  in  1  1 = write, 0 = read.
- `core_addr_i`  in  AW  address.
- `core_wdata_i`  in  DW  write data.
- `core_be_i`  in  SW  byte enables.
- `core_gnt_o`  out  1  request accepted this cycle when `core_req_i` is high; equals `!fifo_full`.
- `core_rvalid_o`  out  1  one-cycle response pulse.
- `core_rdata_o`  out  DW  read data; valid with `core_rvalid_o`.
- `core_err_o`  out  1  response error; valid with `core_rvalid_o`.
- `core_busy_o`  out  1  FIFO non-empty or state ≠ IDLE.
- `wb_addr_o`  out  AW, `wb_data_o`  out  DW, `wb_sel_o`  out  SW, `wb_we_o`  out  1, `wb_stb_o`  out  1, `wb_cyc_o`  out  1: Wishbone master outputs; all registered.
- `wb_data_i`  in  DW, `wb_ack_i`  in  1, `wb_err_i`  in  1: Wishbone slave returns.

## Operation
- **Push:** occurs when `core_req_i && core_gnt_o`; the entry is {we, addr, wdata, be}.
  - `core_gnt_o` depends only on full, with no bypass. When full, a simultaneous pop does not grant in the same cycle.
  - The core has no response backpressure; it must sink every `core_rvalid_o` pulse.
- **FSM states:** IDLE, BUS, RELEASE.
- **IDLE:**
  - If FIFO non-empty: pop head, load `wb_addr_o`/`wb_data_o`/`wb_sel_o`/`wb_we_o` from it, clear the timeout counter, and go to BUS.
  - Otherwise stay in IDLE.
- **BUS:**
  - `wb_stb_o = wb_cyc_o = 1`; address, data, sel and we are held stable.
  - On `wb_err_i`: respond with err=1 and rdata=0. `wb_err_i` wins over a simultaneous `wb_ack_i`.
  - Else on `wb_ack_i`: respond with err=0. rdata = `wb_data_i` for a read, 0 for a write.
  - Else if `TIMEOUT≠0` and the counter equals `TIMEOUT-1`: respond with err=1, rdata=0.
  - Else increment the counter.
  - Any response path drops stb, cyc and we to 0 on the next cycle and moves to RELEASE.
- **RELEASE:**
  - stb = cyc = 0.
  - Go to IDLE when `wb_ack_i` and `wb_err_i` are both low; otherwise stay. This prevents a stretched ack from being credited to the next request.
  - A late ack or err arriving after a timeout is absorbed here and produces no response.
- **Ordering and count:** responses are strictly in request order, exactly one per accepted request.
- **Counter width:** $clog2(TIMEOUT+1); it never wraps.

## Timing
- **Reset values:**
  - All outputs 0, except `core_gnt_o`, which is 1.
  - FIFO empty, state IDLE, counter 0.
- **Reset mid-operation:**
  - On the next edge stb/cyc = 0 and the FIFO is flushed.
  - In-flight and queued requests are dropped with no response.
- **Request latency:** push at edge N; FIFO non-empty in cycle N+1; stb/cyc high from cycle N+2.
- **Response timing:** ack or err sampled high in cycle M gives `core_rvalid_o` high in cycle M+1 only. Stb/cyc are low in cycle M+1.
- **Back-to-back:** with ack held for one cycle (high in M, low in M+1), RELEASE→IDLE occurs at the end of M+1. The next stb then rises in M+3, so the minimum period is 3 idle-to-idle cycles per transfer.
- **Timeout abort:** with no ack or err, stb is high for exactly TIMEOUT cycles. `core_err_o` pulses in the cycle after the last of them.
- **Full FIFO:** `core_gnt_o` is 0 in every cycle where count = REQ_DEPTH. It rises the cycle after a pop.

## Test plan
- **Single read:** write 0x0000_1000 be=0xF, then read with slave ack 2 cycles after stb. Required: stb in cycle N+2; `core_rvalid_o`=1 with rdata=0xDEAD_BEEF and err=0 one cycle after ack; stb=0 that cycle.
- **FIFO fill (REQ_DEPTH=4):** issue 6 requests every cycle with the slave stalled. Required: grant for 4 (5 once the first pop occurs), `core_gnt_o`=0 while full, all 6 complete in order with matching addresses.
- **Stretched ack:** ack held 3 cycles. Required: one response only; next stb not before the cycle after ack falls.
- **Error precedence:** ack and err high together. Required: `core_err_o`=1, rdata=0.
- **Timeout (TIMEOUT=8):** slave never answers. Required: stb high exactly 8 cycles, err response, then a late ack produces no extra rvalid.
- **Reset in BUS with 3 queued:** Required: stb/cyc=0 next cycle, `core_busy_o`=0, no rvalid ever for those 4 requests.

Source files
------------

// File: rtl/wb_core_bridge_if.sv
// rtl/wb_core_bridge_if.sv - core load/store request port and Wishbone master signal bundle
interface wb_core_bridge_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   localparam int SW = DW / 8;

   logic          core_req_i;
   logic          core_we_i;
   logic [AW-1:0] core_addr_i;
   logic [DW-1:0] core_wdata_i;
   logic [SW-1:0] core_be_i;
   logic          core_gnt_o;
   logic          core_rvalid_o;
   logic [DW-1:0] core_rdata_o;
   logic          core_err_o;
   logic          core_busy_o;

   logic [AW-1:0] wb_addr_o;
   logic [DW-1:0] wb_data_o;
   logic [SW-1:0] wb_sel_o;
   logic          wb_we_o;
   logic          wb_stb_o;
   logic          wb_cyc_o;
   logic [DW-1:0] wb_data_i;
   logic          wb_ack_i;
   logic          wb_err_i;

   // Bridge view
   modport master (
      input  core_req_i, core_we_i, core_addr_i, core_wdata_i, core_be_i,
      output core_gnt_o, core_rvalid_o, core_rdata_o, core_err_o, core_busy_o,
      output wb_addr_o, wb_data_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
      input  wb_data_i, wb_ack_i, wb_err_i
   );

   // Environment view (core plus Wishbone slave)
   modport slave (
      output core_req_i, core_we_i, core_addr_i, core_wdata_i, core_be_i,
      input  core_gnt_o, core_rvalid_o, core_rdata_o, core_err_o, core_busy_o,
      input  wb_addr_o, wb_data_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
      output wb_data_i, wb_ack_i, wb_err_i
   );
endinterface

// File: rtl/wb_core_bridge.sv
// rtl/wb_core_bridge.sv - buffered RV32I load/store to Wishbone classic bridge
module wb_core_bridge #(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int REQ_DEPTH = 4,
   parameter int TIMEOUT   = 255
) (
   input  logic              clk_i,
   input  logic              rst,
   wb_core_bridge_if.master  bus
);
   localparam int SW    = DW / 8;
   localparam int PW    = $clog2(REQ_DEPTH);
   localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int EW    = 1 + AW + DW + SW;
   localparam int TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_RELEASE} state_t;

   logic [EW-1:0] r_mem [REQ_DEPTH];
   logic [PW-1:0] r_wr_ptr, r_rd_ptr;
   logic [PW:0]   r_count;
   logic          w_full, w_empty, w_push, w_pop;
   logic [EW-1:0] w_head;

   state_t        r_state, w_state_nxt;
   logic [AW-1:0] r_addr, w_addr_nxt;
   logic [DW-1:0] r_data, w_data_nxt;
   logic [SW-1:0] r_sel, w_sel_nxt;
   logic          r_we, w_we_nxt;
   logic          r_stb, w_stb_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic          r_rvalid, w_rvalid_nxt;
   logic [DW-1:0] r_rdata, w_rdata_nxt;
   logic          r_err, w_err_nxt;
   logic          w_respond;

   // Grant depends on occupancy only, so a pop never frees a slot in the same cycle
   assign w_full  = (r_count == (PW+1)'(REQ_DEPTH));
   assign w_empty = (r_count == '0);
   assign w_push  = bus.core_req_i && !w_full;
   assign w_head  = r_mem[r_rd_ptr];

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {bus.core_we_i, bus.core_addr_i, bus.core_wdata_i, bus.core_be_i};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_addr   <= '0;
         r_data   <= '0;
         r_sel    <= '0;
         r_we     <= 1'b0;
         r_stb    <= 1'b0;
         r_cnt    <= '0;
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_addr   <= w_addr_nxt;
         r_data   <= w_data_nxt;
         r_sel    <= w_sel_nxt;
         r_we     <= w_we_nxt;
         r_stb    <= w_stb_nxt;
         r_cnt    <= w_cnt_nxt;
         r_rvalid <= w_rvalid_nxt;
         r_rdata  <= w_rdata_nxt;
         r_err    <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_addr_nxt   = r_addr;
      w_data_nxt   = r_data;
      w_sel_nxt    = r_sel;
      w_we_nxt     = r_we;
      w_stb_nxt    = r_stb;
      w_cnt_nxt    = r_cnt;
      w_rvalid_nxt = 1'b0;
      w_rdata_nxt  = r_rdata;
      w_err_nxt    = r_err;
      w_pop        = 1'b0;
      w_respond    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_we_nxt    = w_head[EW-1];
               w_addr_nxt  = w_head[EW-2 -: AW];
               w_data_nxt  = w_head[DW+SW-1 -: DW];
               w_sel_nxt   = w_head[SW-1:0];
               w_cnt_nxt   = '0;
               w_stb_nxt   = 1'b1;
               w_state_nxt = S_BUS;
            end
         end
         S_BUS: begin
            if (bus.wb_err_i) begin
               w_respond   = 1'b1;
               w_err_nxt   = 1'b1;
               w_rdata_nxt = '0;
            end else if (bus.wb_ack_i) begin
               w_respond   = 1'b1;
               w_err_nxt   = 1'b0;
               w_rdata_nxt = r_we ? '0 : bus.wb_data_i;
            end else if ((TIMEOUT != 0) && (r_cnt == CW'(TLAST))) begin
               w_respond   = 1'b1;
               w_err_nxt   = 1'b1;
               w_rdata_nxt = '0;
            end else if (r_cnt != '1) begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
            if (w_respond) begin
               w_rvalid_nxt = 1'b1;
               w_stb_nxt    = 1'b0;
               w_we_nxt     = 1'b0;
               w_state_nxt  = S_RELEASE;
            end
         end
         S_RELEASE: begin
            // A stretched or late ack/err is swallowed here rather than credited onward
            if (!bus.wb_ack_i && !bus.wb_err_i) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign bus.core_gnt_o    = !w_full;
   assign bus.core_rvalid_o = r_rvalid;
   assign bus.core_rdata_o  = r_rdata;
   assign bus.core_err_o    = r_err;
   assign bus.core_busy_o   = !w_empty || (r_state != S_IDLE);
   assign bus.wb_addr_o     = r_addr;
   assign bus.wb_data_o     = r_data;
   assign bus.wb_sel_o      = r_sel;
   assign bus.wb_we_o       = r_we;
   assign bus.wb_stb_o      = r_stb;
   assign bus.wb_cyc_o      = r_stb;
endmodule

// File: tb/tb_wb_core_bridge.sv
// tb/tb_wb_core_bridge.sv - directed and randomized bench with a transaction-level reference model
module tb_wb_core_bridge;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int DEPTH = 4;
   localparam int TMO = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_core_bridge_if #(.AW(AW), .DW(DW)) bus ();

   wb_core_bridge #(.AW(AW), .DW(DW), .REQ_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
      .clk_i (clk),
      .rst   (rst),
      .bus   (bus)
   );

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [SW-1:0] be;
   } req_t;

   typedef struct {
      int            due;
      logic          err;
      logic [DW-1:0] rdata;
   } exp_t;

   req_t pend_q[$];
   req_t req_q[$];
   exp_t exp_q[$];

   int checks = 0, failures = 0, cyc_n = 0;
   int acc = 0, rises = 0, n_resp = 0;
   int last_hi = -100, last_rise = 0, last_acc = 0, last_gap = 0, last_len = 0;
   int age = 0, hold_left = 0;
   bit stb_prev = 0, responded = 1, resp_prev = 0, rnd_mode = 0, man_ack = 0;
   int cur_delay = 0, cur_len = 1, cur_kind = 0;
   bit cur_rd = 0;
   int d_delay = 1, d_len = 1, d_kind = 0;    // kind: 0 ack, 1 err, 2 ack+err, 3 silent
   logic [DW-1:0] d_rdata = '0;
   logic [DW-1:0] last_rdata = '0;
   logic last_err = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic flush_model();
      pend_q.delete();
      req_q.delete();
      exp_q.delete();
      acc = 0; rises = 0; n_resp = 0;
      stb_prev = 0; resp_prev = 0; hold_left = 0; responded = 1;
      last_hi = -100;
      bus.core_req_i = 1'b0;
      bus.wb_ack_i = 1'b0;
      bus.wb_err_i = 1'b0;
   endtask

   task automatic push_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [SW-1:0] be);
      req_t r;
      r.we = we; r.addr = addr; r.data = data; r.be = be;
      pend_q.push_back(r);
   endtask

   // One clock: sample DUT, score it, then drive core and slave inputs for this cycle
   task automatic cyc();
      exp_t e;
      req_t r;
      logic a, er;
      logic [DW-1:0] rd;
      @(posedge clk);
      #1;
      cyc_n++;
      if (bus.core_rvalid_o) begin
         n_resp++;
         last_rdata = bus.core_rdata_o;
         last_err = bus.core_err_o;
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc_n) begin
         e = exp_q.pop_front();
         chk("rvalid", bus.core_rvalid_o, 1);
         chk("rdata", bus.core_rdata_o, e.rdata);
         chk("err", bus.core_err_o, e.err);
      end else begin
         chk("no_rvalid", bus.core_rvalid_o, 0);
      end
      if (resp_prev) begin
         chk("stb_after_resp", bus.wb_stb_o, 0);
         resp_prev = 0;
      end
      chk("cyc_eq_stb", bus.wb_cyc_o, bus.wb_stb_o);
      if (bus.wb_stb_o) begin
         if (!stb_prev) begin
            rises++;
            last_rise = cyc_n;
            last_gap = cyc_n - last_hi;
            if (last_hi > -100) chk("gap_after_ack", (last_gap >= 3), 1);
            age = 0;
            responded = 0;
            if (req_q.size() == 0) begin
               chk("stb_without_req", 0, 1);
               cur_rd = 1;
            end else begin
               r = req_q.pop_front();
               chk("order_addr", bus.wb_addr_o, r.addr);
               chk("order_we", bus.wb_we_o, r.we);
               chk("order_sel", bus.wb_sel_o, r.be);
               chk("order_data", bus.wb_data_o, r.data);
               cur_rd = !r.we;
            end
            if (rnd_mode) begin
               cur_delay = $urandom_range(0, 3);
               cur_len = $urandom_range(1, 2);
               case ($urandom_range(0, 15))
                  0: cur_kind = 3;
                  1: cur_kind = 1;
                  2: cur_kind = 2;
                  default: cur_kind = 0;
               endcase
            end else begin
               cur_delay = d_delay; cur_len = d_len; cur_kind = d_kind;
            end
         end else begin
            age++;
         end
         chk("stb_within_timeout", (age < TMO), 1);
      end else if (stb_prev) begin
         last_len = age + 1;
      end
      stb_prev = bus.wb_stb_o;
      chk("gnt_model", bus.core_gnt_o, ((acc - rises) < DEPTH));

      a = 1'b0; er = 1'b0;
      if (hold_left > 0) begin
         a = (cur_kind == 0 || cur_kind == 2);
         er = (cur_kind == 1 || cur_kind == 2);
         hold_left--;
      end else if (bus.wb_stb_o && !responded) begin
         if (cur_kind != 3 && age == cur_delay) begin
            responded = 1;
            hold_left = cur_len - 1;
            a = (cur_kind == 0 || cur_kind == 2);
            er = (cur_kind == 1 || cur_kind == 2);
            rd = rnd_mode ? DW'($urandom) : d_rdata;
            bus.wb_data_i = rd;
            e.due = cyc_n + 1;
            e.err = (cur_kind != 0);
            e.rdata = (cur_kind == 0 && cur_rd) ? rd : '0;
            exp_q.push_back(e);
            resp_prev = 1;
         end else if (cur_kind == 3 && age == TMO - 1) begin
            responded = 1;
            e.due = cyc_n + 1;
            e.err = 1'b1;
            e.rdata = '0;
            exp_q.push_back(e);
            resp_prev = 1;
         end
      end
      bus.wb_ack_i = a | man_ack;
      bus.wb_err_i = er;
      if (a | er | man_ack) last_hi = cyc_n;

      if (pend_q.size() > 0) begin
         r = pend_q[0];
         bus.core_req_i = 1'b1;
         bus.core_we_i = r.we;
         bus.core_addr_i = r.addr;
         bus.core_wdata_i = r.data;
         bus.core_be_i = r.be;
         if (bus.core_gnt_o) begin
            req_q.push_back(pend_q.pop_front());
            acc++;
            last_acc = cyc_n;
         end
      end else begin
         bus.core_req_i = 1'b0;
      end
   endtask

   task automatic drain(input int max_cyc);
      bit done;
      done = 0;
      for (int i = 0; i < max_cyc; i++) begin
         done = (pend_q.size() == 0) && (req_q.size() == 0) && (exp_q.size() == 0) &&
                (hold_left == 0) && !bus.wb_stb_o && !bus.core_busy_o;
         if (done) break;
         cyc();
      end
      chk("drain_done", done, 1);
      chk("resp_count", n_resp, acc);
   endtask

   initial begin
      bus.core_req_i = 1'b0;
      bus.core_we_i = 1'b0;
      bus.core_addr_i = '0;
      bus.core_wdata_i = '0;
      bus.core_be_i = '0;
      bus.wb_data_i = '0;
      bus.wb_ack_i = 1'b0;
      bus.wb_err_i = 1'b0;

      // Reset state
      cyc();
      cyc();
      chk("rst_stb", bus.wb_stb_o, 0);
      chk("rst_we", bus.wb_we_o, 0);
      chk("rst_addr", bus.wb_addr_o, 0);
      chk("rst_data", bus.wb_data_o, 0);
      chk("rst_sel", bus.wb_sel_o, 0);
      chk("rst_rdata", bus.core_rdata_o, 0);
      chk("rst_err", bus.core_err_o, 0);
      chk("rst_busy", bus.core_busy_o, 0);
      chk("rst_gnt", bus.core_gnt_o, 1);
      rst = 1'b0;
      cyc();

      // Write then read with ack two cycles after stb
      d_kind = 0; d_delay = 1; d_len = 1;
      push_req(1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF);
      drain(40);
      d_delay = 2; d_rdata = 32'hDEAD_BEEF;
      push_req(1'b0, 32'h0000_1000, 32'h0, 4'hF);
      drain(40);
      chk("rd_stb_latency", last_rise - last_acc, 2);
      chk("rd_rdata", last_rdata, 32'hDEAD_BEEF);
      chk("rd_err", last_err, 0);

      // FIFO fill with a stalled slave
      d_delay = 5; d_rdata = 32'h5555_AAAA;
      begin
         int a0;
         a0 = acc;
         for (int i = 0; i < 6; i++) push_req(i[0], 32'h2000 + 32'(4 * i), 32'(i), 4'(i + 1));
         for (int i = 0; i < 6; i++) cyc();
         chk("fill_granted", acc - a0, 5);
         chk("fill_gnt_low", bus.core_gnt_o, 0);
      end
      drain(200);

      // Stretched ack, then single-cycle ack back-to-back
      d_delay = 0; d_len = 3; d_rdata = 32'h0BAD_F00D;
      push_req(1'b0, 32'h3000, 32'h0, 4'h3);
      push_req(1'b0, 32'h3004, 32'h0, 4'hC);
      drain(60);
      chk("stretch_gap", last_gap, 3);
      d_len = 1;
      push_req(1'b1, 32'h3008, 32'hAAAA_0001, 4'h1);
      push_req(1'b0, 32'h300C, 32'h0, 4'hF);
      drain(60);
      chk("b2b_gap", last_gap, 3);

      // Error wins over simultaneous ack
      d_kind = 2; d_delay = 1; d_rdata = 32'hCAFE_0001;
      push_req(1'b0, 32'h4000, 32'h0, 4'hF);
      drain(40);
      chk("errprec_err", last_err, 1);
      chk("errprec_rdata", last_rdata, 0);

      // Timeout, late ack absorbed in RELEASE, following request unaffected
      d_kind = 3;
      push_req(1'b0, 32'h5000, 32'h0, 4'hF);
      push_req(1'b0, 32'h5004, 32'h0, 4'hF);
      begin
         bit hit;
         hit = 0;
         for (int i = 0; i < 50; i++) begin
            cyc();
            if (resp_prev) begin hit = 1; break; end
         end
         chk("tmo_reached", hit, 1);
      end
      d_kind = 0; d_delay = 1; d_rdata = 32'h7777_0000;
      cyc();
      chk("tmo_stb_len", last_len, TMO);
      chk("tmo_err", last_err, 1);
      man_ack = 1;
      bus.wb_ack_i = 1'b1;
      last_hi = cyc_n;
      cyc();
      cyc();
      man_ack = 0;
      drain(80);

      // Reset while in BUS with three requests queued
      d_kind = 3;
      for (int i = 0; i < 4; i++) push_req(1'b0, 32'h6000 + 32'(4 * i), 32'h0, 4'hF);
      begin
         bit hit;
         hit = 0;
         for (int i = 0; i < 50; i++) begin
            cyc();
            if (pend_q.size() == 0 && bus.wb_stb_o) begin hit = 1; break; end
         end
         chk("rst_mid_setup", hit, 1);
      end
      rst = 1'b1;
      flush_model();
      cyc();
      chk("rst_mid_stb", bus.wb_stb_o, 0);
      chk("rst_mid_cyc", bus.wb_cyc_o, 0);
      chk("rst_mid_busy", bus.core_busy_o, 0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) cyc();
      chk("rst_mid_no_stb", rises, 0);
      chk("rst_mid_no_resp", n_resp, 0);

      // Randomized traffic against the scoreboard
      rnd_mode = 1;
      for (int i = 0; i < 600; i++) begin
         if (pend_q.size() < 3 && $urandom_range(0, 2) == 0)
            push_req(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
                     4'($urandom_range(0, 15)));
         cyc();
      end
      drain(400);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
